// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e      : transmit FSM states (PARITY is only reachable when
//                     UART_TX_PARITY_EN is defined)
//   baud_div()      : clock cycles per line bit, rounded to nearest
//   UART_IDLE_LEVEL : line level between frames
//   DATA_BITS       : payload bits per frame
package uart_pkg;

  localparam logic        UART_IDLE_LEVEL = 1'b1;
  localparam int unsigned DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with synchronous active-high reset.
// Ports:
//   clk, rst     : clock and synchronous reset (flushes contents)
//   push, wdata  : write request and data; ignored while full
//   pop          : read request; ignored while empty
//   rdata        : current head entry (valid while !empty)
//   full, empty  : status derived from pointer MSB compare
//   count        : entries held, $clog2(DEPTH)+1 bits
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Pointers carry one extra wrap bit: equal low bits with differing MSBs means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes arrive over valid/ready, are queued in a
// FIFO and serialised back-to-back, LSB first, 8N1 (8E1 with parity).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit.
// Ports:
//   clk_i        : clock, all logic on rising edge
//   rst_i        : synchronous active-high reset, aborts frame, flushes FIFO
//   tx_data_i    : byte to send
//   tx_valid_i   : tx_data_i valid; push = tx_valid_i & tx_ready_o
//   tx_ready_o   : FIFO not full (registered count based)
//   txd_o        : serial line, idle high
//   tx_busy_o    : frame in progress or FIFO non-empty
//   fifo_count_o : bytes queued, excluding the byte being shifted
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [7:0]                  tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic                        txd_o,
  output logic                        tx_busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int unsigned DIV  = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [DATA_BITS-1:0]   head;
  logic                   bit_end;

  assign tx_ready_o = (fifo_count_o != CNTW'(FIFO_DEPTH));
  assign push       = tx_valid_i & tx_ready_o;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (tx_data_i),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count_o)
  );

  assign bit_end = (cnt_q == CW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        txd_d = UART_IDLE_LEVEL;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^head;
`endif
          cnt_d   = '0;
          txd_d   = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          txd_d   = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // txd is registered, so the next line bit is presented one step early:
      // shift_q[1] becomes shift_q[0] at the same edge the register shifts.
      DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d   = par_q;
            state_d = PARITY;
`else
            txd_d   = UART_IDLE_LEVEL;
            state_d = STOP;
`endif
          end else begin
            txd_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          txd_d   = UART_IDLE_LEVEL;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^head;
`endif
            txd_d   = 1'b0;
            state_d = START;
          end else begin
            txd_d   = UART_IDLE_LEVEL;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        txd_d   = UART_IDLE_LEVEL;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign txd_o     = txd_q;
  assign tx_busy_o = (state_q != IDLE) | (fifo_count_o != '0);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered. Runs at CLK_FREQ=1_000_000, BAUD=57_600,
// giving (1_000_000 + 28_800) / 57_600 = 17 cycles per bit.
// Expected bytes are queued when pushed; a line monitor decodes frames and
// compares each against the queue head.
module tb_uart_tx_buffered;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 57_600;
  localparam int DEPTH    = 16;
  localparam int DIV      = 17;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic [4:0] fifo_count;

  uart_tx_buffered #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .txd_o        (txd),
    .tx_busy_o    (tx_busy),
    .fifo_count_o (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rst_edges = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_edges <= rst_edges + 1;
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frame_starts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line monitor: samples mid-bit on falling clock edges.
  initial begin : monitor
    logic [7:0] b;
    logic       s0, stp, par;
    int         r0;
    par = 1'b0;
    forever begin
      @(negedge clk);
      if (txd === 1'b0 && !rst) begin
        r0 = rst_edges;
        frame_starts++;
        start_q.push_back(cyc);
        repeat (DIV / 2) @(negedge clk);
        s0 = txd;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        par = txd;
`endif
        repeat (DIV) @(negedge clk);
        stp = txd;
        if (rst_edges == r0) begin
          check("start_bit", {31'd0, s0}, 32'd0);
          check("stop_bit", {31'd0, stp}, 32'd1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", {31'd0, par}, {31'd0, ^b});
`endif
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got %02h expected none", b);
          end else begin
            check("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          end
        end
        repeat (DIV - 1 - DIV / 2) @(negedge clk);
      end
    end
  end

  // Called on a falling edge; returns on the falling edge after the push edge
  // with pc = index of that push edge. tx_valid is left high.
  task automatic push(input logic [7:0] b, output int pc);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (tx_ready !== 1'b1 && n < 12 * FB * DIV) begin
      @(negedge clk);
      n++;
    end
    if (tx_ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL push_timeout: got ready=%b expected 1", tx_ready);
    end
    @(posedge clk);
    @(negedge clk);
    pc = cyc;
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int budget, output int ic);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx_busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%b expected 0", tx_busy);
    end
    ic = cyc;
  endtask

  function automatic int first_start();
    return (start_q.size() > 0) ? start_q[0] : -1;
  endfunction

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pc, pc0, ic, fs, line_bad, target;

    // Reset held 3 cycles with valid high: nothing may be accepted.
    @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b1;
    tx_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_count", {27'd0, fifo_count}, 32'd0);
    end
    rst = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("post_rst_count", {27'd0, fifo_count}, 32'd0);
    check("post_rst_busy", {31'd0, tx_busy}, 32'd0);
    repeat (5) @(negedge clk);

    // Single byte 0x55: start bit on the edge after the push edge.
    start_q.delete();
    push(8'h55, pc);
    tx_valid = 1'b0;
    wait_idle(3 * FB * DIV, ic);
    check("single_frames", start_q.size(), 32'd1);
    check("single_latency", first_start(), pc + 1);
    check("single_frame_len", ic, pc + 1 + FB * DIV);
    repeat (5) @(negedge clk);

    // Burst 0x00..0x11 with valid held: 17 accepted, then full.
    start_q.delete();
    push(8'h00, pc0);
    for (int i = 1; i <= 16; i++) push(8'(i), pc);
    check("burst_count_full", {27'd0, fifo_count}, 32'd16);
    check("burst_ready_low", {31'd0, tx_ready}, 32'd0);
    check("burst_17th_edge", pc, pc0 + 16);
    tx_data = 8'h11;
    repeat (5 * DIV) @(negedge clk);
    check("burst_hold_count", {27'd0, fifo_count}, 32'd16);
    check("burst_hold_ready", {31'd0, tx_ready}, 32'd0);
    push(8'h11, pc);
    tx_valid = 1'b0;
    check("burst_last_push", pc, pc0 + FB * DIV + 2);
    wait_idle(20 * FB * DIV, ic);
    check("burst_frames", start_q.size(), 32'd18);
    check("burst_all_rx", exp_q.size(), 32'd0);
    repeat (5) @(negedge clk);

    // Back-to-back 0xA5, 0x3C: no idle gap between frames.
    start_q.delete();
    push(8'hA5, pc);
    push(8'h3C, pc);
    tx_valid = 1'b0;
    wait_idle(4 * FB * DIV, ic);
    check("b2b_frames", start_q.size(), 32'd2);
    check("b2b_gap", (start_q.size() > 1) ? start_q[1] - start_q[0] : -1, FB * DIV);
    check("b2b_total", ic - first_start(), 2 * FB * DIV);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 of 0xF0 with two bytes queued.
    start_q.delete();
    push(8'hF0, pc0);
    push(8'h01, pc);
    push(8'h02, pc);
    tx_valid = 1'b0;
    check("abort_queued", {27'd0, fifo_count}, 32'd2);
    target = pc0 + 1 + 4 * DIV + DIV / 2;
    while (cyc < target) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_txd", {31'd0, txd}, 32'd1);
    check("abort_count", {27'd0, fifo_count}, 32'd0);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_ready", {31'd0, tx_ready}, 32'd1);
    fs = frame_starts;
    line_bad = 0;
    repeat (3 * FB * DIV) begin
      @(negedge clk);
      if (txd !== 1'b1) line_bad++;
    end
    check("abort_line_idle", line_bad, 32'd0);
    check("abort_no_frames", frame_starts, fs);
    check("abort_busy_after", {31'd0, tx_busy}, 32'd0);

    // 0x07: frame length 10 bits (11 with parity, parity bit 1).
    start_q.delete();
    push(8'h07, pc);
    tx_valid = 1'b0;
    wait_idle(3 * FB * DIV, ic);
    check("x07_latency", first_start(), pc + 1);
    check("x07_frame_len", ic, pc + 1 + FB * DIV);
    repeat (5) @(negedge clk);

    check("all_received", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
